// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: memory request/response, decode handshake and redirect.
interface fetch_queue_if;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  // Fetch queue side
  modport master (
    output o_mem_req_valid, o_mem_req_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_inst_ready,
           i_redirect, i_redirect_pc
  );

  // Memory / decode / execute side
  modport slave (
    input  o_mem_req_valid, o_mem_req_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_inst_ready,
           i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential word requests, in-order responses
// buffered with their PCs, valid/ready delivery to decode, redirect flush.
module fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  logic          credit_ok;
  logic          req_valid_c;
  logic          req_fire;
  logic          inst_valid_c;
  logic          pop;
  logic          push;
  logic          rsp_drop;
  logic [31:0]   target;

  // Low address bits of the redirect target are forced to zero
  wire unused_redirect_lsb = &{1'b0, bus.i_redirect_pc[1:0]};

  // Handshake decode; buffered + outstanding fetches never exceed DEPTH
  always_comb begin
    credit_ok    = (SW'(count) + SW'(inflight)) < SW'(DEPTH);
    req_valid_c  = !i_rst && !bus.i_redirect && credit_ok;
    req_fire     = req_valid_c && bus.i_mem_req_ready;
    inst_valid_c = !i_rst && !bus.i_redirect && (count != '0);
    pop          = inst_valid_c && bus.i_inst_ready;
    rsp_drop     = (drop != '0);
    push         = bus.i_mem_rsp_valid && !rsp_drop && !bus.i_redirect && !i_rst;
    target       = {bus.i_redirect_pc[31:2], 2'b00};
  end

  assign bus.o_mem_req_valid = req_valid_c;
  assign bus.o_mem_req_addr  = i_rst ? RESET_ADDR : fpc;
  assign bus.o_inst_valid    = inst_valid_c;
  assign bus.o_inst          = fifo_inst[rd_ptr];
  assign bus.o_inst_pc       = fifo_pc[rd_ptr];

  // Control state: PCs, pointers and the count/inflight/drop credit counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpc      <= RESET_ADDR;
      rpc      <= RESET_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.i_redirect) begin
      fpc      <= target;
      rpc      <= target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(bus.i_mem_rsp_valid);
      drop     <= inflight - CW'(bus.i_mem_rsp_valid);
    end else begin
      if (req_fire) fpc <= fpc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(bus.i_mem_rsp_valid);
      if (bus.i_mem_rsp_valid && rsp_drop) drop <= drop - CW'(1);
      if (push) begin
        rpc    <= rpc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Instruction/PC storage, written on each accepted response
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.i_mem_rsp_data;
      fifo_pc[wr_ptr]   <= rpc;
    end
  end

endmodule
